// File: rtl/serial_mag_cmp.sv
//------------------------------------------------------------------------------
// serial_mag_cmp : MSB-first serial magnitude resolver over 2-bit digit compares
// Optional: SERIAL_CMP_EARLY_EXIT_EN ends the frame after the first decisive digit
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module serial_mag_cmp #(
   parameter int DIGITS = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic inStart,
   input  logic inValid,
   input  logic inGT,
   input  logic inEQ,
   input  logic inLT,
   output logic outReady,
   output logic outBusy,
   output logic outDone,
   output logic outGT,
   output logic outEQ,
   output logic outLT,
   output logic outErr
);

   localparam int            CW   = $clog2(DIGITS + 1);
   localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
   localparam bit EARLY_EXIT = 1'b1;
`else
   localparam bit EARLY_EXIT = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic          decided_q, decided_d;
   logic          dir_gt_q, dir_gt_d;
   logic          res_gt_q, res_gt_d;
   logic          res_eq_q, res_eq_d;
   logic          res_lt_q, res_lt_d;
   logic          err_q, err_d;

   logic accept;
   logic code_ok;
   logic decisive;

   assign accept   = (state_q == S_RUN) && inValid;
   assign code_ok  = (inGT ^ inEQ ^ inLT) & ~(inGT & inEQ & inLT);
   assign decisive = code_ok & (inGT | inLT);

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      decided_d = decided_q;
      dir_gt_d  = dir_gt_q;
      res_gt_d  = res_gt_q;
      res_eq_d  = res_eq_q;
      res_lt_d  = res_lt_q;
      err_d     = err_q;

      case (state_q)
         S_RUN: begin
            if (accept) begin
               count_d = count_q + CW'(1);
               if (!code_ok) begin
                  err_d = 1'b1;
               end
               if (!decided_q && decisive) begin
                  decided_d = 1'b1;
                  dir_gt_d  = inGT;
               end
               // The final digit's own decision is folded in before the result is latched.
               if ((count_q == LAST) || (EARLY_EXIT && !decided_q && decisive)) begin
                  state_d  = S_DONE;
                  res_gt_d = decided_d & dir_gt_d;
                  res_lt_d = decided_d & ~dir_gt_d;
                  res_eq_d = ~decided_d;
               end
            end
         end
         default: begin
            if (state_q == S_DONE) begin
               state_d = S_IDLE;
            end
            if (inStart) begin
               state_d   = S_RUN;
               count_d   = '0;
               decided_d = 1'b0;
               dir_gt_d  = 1'b0;
               res_gt_d  = 1'b0;
               res_eq_d  = 1'b0;
               res_lt_d  = 1'b0;
               err_d     = 1'b0;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         count_q   <= '0;
         decided_q <= 1'b0;
         dir_gt_q  <= 1'b0;
         res_gt_q  <= 1'b0;
         res_eq_q  <= 1'b0;
         res_lt_q  <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         decided_q <= decided_d;
         dir_gt_q  <= dir_gt_d;
         res_gt_q  <= res_gt_d;
         res_eq_q  <= res_eq_d;
         res_lt_q  <= res_lt_d;
         err_q     <= err_d;
      end
   end

   assign outReady = (state_q == S_RUN);
   assign outBusy  = (state_q == S_RUN);
   assign outDone  = (state_q == S_DONE);
   assign outGT    = res_gt_q;
   assign outEQ    = res_eq_q;
   assign outLT    = res_lt_q;
   assign outErr   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_mag_cmp.sv
//------------------------------------------------------------------------------
// tb_serial_mag_cmp : random and directed frames against an integer-compare model
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_mag_cmp;

   localparam int DIGITS = 4;
   localparam int W      = 2 * DIGITS;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic inStart = 1'b0, inValid = 1'b0;
   logic inGT = 1'b0, inEQ = 1'b0, inLT = 1'b0;
   logic outReady, outBusy, outDone, outGT, outEQ, outLT, outErr;

   int n_vec  = 0;
   int n_fail = 0;

   serial_mag_cmp #(.DIGITS(DIGITS)) dut (
      .clk(clk), .reset_n(reset_n), .inStart(inStart), .inValid(inValid),
      .inGT(inGT), .inEQ(inEQ), .inLT(inLT),
      .outReady(outReady), .outBusy(outBusy), .outDone(outDone),
      .outGT(outGT), .outEQ(outEQ), .outLT(outLT), .outErr(outErr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:0] dig(input logic [W-1:0] v, input int k);
      return v[2*(DIGITS-1-k) +: 2];
   endfunction

   function automatic logic [2:0] bad_code();
      logic [2:0] tbl [5];
      tbl = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
      return tbl[$urandom_range(4, 0)];
   endfunction

   // Drives one frame MSB digit first; vpat gives inValid per cycle (LSB first).
   task automatic run_frame(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [DIGITS-1:0] errm, input logic [31:0] vpat);
      logic [W-1:0] bm;
      logic [2:0]   exp_res;
      logic [2:0]   code;
      logic [1:0]   da, db;
      logic [31:0]  pat;
      int           exp_acc, acc, cyc, last_acc;
      bit           exp_err, done, take;

      // Corrupted digits are treated as equal: copy A's digit into B.
      bm = b;
      for (int k = 0; k < DIGITS; k++)
         if (errm[k]) bm[2*(DIGITS-1-k) +: 2] = dig(a, k);
      exp_res = (a > bm) ? 3'b100 : (a == bm) ? 3'b010 : 3'b001;

      exp_acc = DIGITS;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      for (int k = DIGITS - 1; k >= 0; k--)
         if (dig(a, k) != dig(bm, k)) exp_acc = k + 1;
`endif
      exp_err = 1'b0;
      for (int k = 0; k < exp_acc; k++)
         if (errm[k]) exp_err = 1'b1;

      inStart = 1'b1;
      inValid = 1'b0;
      @(posedge clk); #1;
      inStart = 1'b0;
      chk("run_busy", outBusy, 1);
      chk("run_ready", outReady, 1);
      chk("run_res_clear", {outGT, outEQ, outLT}, 3'b000);
      chk("run_err_clear", outErr, 0);

      acc = 0; cyc = 1; last_acc = -100; done = 1'b0; pat = vpat;
      while (!done && cyc < 4 * DIGITS + 40) begin
         if (outDone) begin
            done = 1'b1;
         end else begin
            inValid = (cyc <= 32) ? pat[0] : 1'b1;
            pat = pat >> 1;
            if (acc < DIGITS) begin
               da = dig(a, acc);
               db = dig(b, acc);
               code = errm[acc] ? bad_code() : {da > db, da == db, da < db};
            end else begin
               code = 3'b010;
            end
            {inGT, inEQ, inLT} = code;
            take = inValid && outReady;
            @(posedge clk); #1;
            if (take) begin
               acc++;
               last_acc = cyc;
            end
            cyc++;
         end
      end
      inValid = 1'b0;
      {inGT, inEQ, inLT} = 3'b000;

      if (!done) begin
         chk("done_timeout", 0, 1);
      end else begin
         chk("accepts", acc, exp_acc);
         chk("done_latency", cyc, last_acc + 1);
         chk("result", {outGT, outEQ, outLT}, exp_res);
         chk("err", outErr, exp_err);
         chk("ready_in_done", outReady, 0);
         @(posedge clk); #1;
         chk("done_pulse", outDone, 0);
         chk("result_hold", {outGT, outEQ, outLT}, exp_res);
         chk("busy_idle", outBusy, 0);
      end
   endtask

   initial begin
      logic [W-1:0]      a, b;
      logic [DIGITS-1:0] em;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_outs", {outReady, outBusy, outDone, outGT, outEQ, outLT, outErr}, 7'd0);
      @(negedge clk) reset_n = 1'b1;
      @(posedge clk); #1;

      run_frame(8'hB4, 8'hB4, '0, '1);
      run_frame(8'h93, 8'h87, '0, '1);
      run_frame(8'h93, 8'h87, '0, 32'hFFFF_FF00 | 32'b1011001);
      run_frame(8'hB4, 8'hB4, 4'b0100, '1);
      run_frame(8'h5A, 8'h5B, '0, '1);

      // Reset mid-frame after two accepted digits, the first one malformed.
      inStart = 1'b1;
      @(posedge clk); #1;
      inStart = 1'b0;
      inValid = 1'b1;
      {inGT, inEQ, inLT} = 3'b000;
      @(posedge clk); #1;
      {inGT, inEQ, inLT} = 3'b100;
      @(posedge clk); #1;
      chk("pre_rst_err", outErr, 1);
      chk("pre_rst_busy", outBusy, 1);
      #2 reset_n = 1'b0;
      #1;
      chk("async_rst_outs", {outReady, outBusy, outDone, outGT, outEQ, outLT, outErr}, 7'd0);
      @(negedge clk) reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("post_rst_idle", {outReady, outBusy, outDone}, 3'b000);
      end
      inValid = 1'b0;
      run_frame(8'h12, 8'h34, '0, '1);

      for (int f = 0; f < 30; f++) begin
         a = W'($urandom);
         b = W'($urandom);
         if ($urandom_range(1, 0) == 1) begin
            b = a;
            b[2*$urandom_range(DIGITS-1, 0) +: 2] = 2'($urandom);
         end
         em = ($urandom_range(3, 0) == 0) ? DIGITS'($urandom) : '0;
         run_frame(a, b, em, $urandom | $urandom);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
